// File: rtl/ram_arbiter_if.sv
// Bundle of the two requester ports, the shared basic_ram bus and status for ram_arbiter.
// The arbiter connects through the slave modport; the requesters and RAM sit on the master side.
interface ram_arbiter_if;
  logic        boot_lock;

  logic        p0_req;
  logic        p0_we;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic [1:0]  p0_size;
  logic        p0_ack;
  logic        p0_err;
  logic [31:0] p0_rdata;

  logic        p1_req;
  logic        p1_we;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic [1:0]  p1_size;
  logic        p1_ack;
  logic        p1_err;
  logic [31:0] p1_rdata;

  logic        ram_cs;
  logic        ram_we;
  logic        ram_oe;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic [1:0]  ram_size;
  logic [31:0] ram_dout;
  logic        ram_ready;

  logic        busy;

  modport slave (
    input  boot_lock,
    input  p0_req, p0_we, p0_addr, p0_wdata, p0_size,
    output p0_ack, p0_err, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata, p1_size,
    output p1_ack, p1_err, p1_rdata,
    output ram_cs, ram_we, ram_oe, ram_addr, ram_din, ram_size,
    input  ram_dout, ram_ready,
    output busy
  );

  modport master (
    output boot_lock,
    output p0_req, p0_we, p0_addr, p0_wdata, p0_size,
    input  p0_ack, p0_err, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata, p1_size,
    input  p1_ack, p1_err, p1_rdata,
    input  ram_cs, ram_we, ram_oe, ram_addr, ram_din, ram_size,
    output ram_dout, ram_ready,
    input  busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one basic_ram port between the boot loader (port 0) and the core (port 1),
// with a loader-priority lock and a ready-timeout watchdog that completes the access with an error.
module ram_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input logic           clk,
  input logic           rst_n,
  ram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_q, last_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      din_q, din_d;
  logic [1:0]       size_q, size_d;
  logic [31:0]      rdata0_q, rdata0_d;
  logic [31:0]      rdata1_q, rdata1_d;
  logic             winner;

  // Loader lock beats fairness; otherwise a contended grant goes to the port not served last.
  always_comb begin
    if (bus.boot_lock)
      winner = !bus.p0_req;
    else if (bus.p0_req && bus.p1_req)
      winner = !last_q;
    else
      winner = bus.p1_req;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    din_d    = din_q;
    size_d   = size_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    case (state_q)
      IDLE: begin
        if (bus.p0_req || bus.p1_req) begin
          grant_d = winner;
          last_d  = winner;
          we_d    = winner ? bus.p1_we    : bus.p0_we;
          addr_d  = winner ? bus.p1_addr  : bus.p0_addr;
          din_d   = winner ? bus.p1_wdata : bus.p0_wdata;
          size_d  = winner ? bus.p1_size  : bus.p0_size;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // A ready seen on the final allowed cycle still counts as a normal completion.
        if (bus.ram_ready) begin
          if (!we_q) begin
            if (grant_q) rdata1_d = bus.ram_dout;
            else         rdata0_d = bus.ram_dout;
          end
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      size_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      size_q   <= size_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Strobes decode from the state register, so an async reset drops them at once.
  assign bus.ram_cs   = (state_q == ACCESS);
  assign bus.ram_we   = (state_q == ACCESS) && we_q;
  assign bus.ram_oe   = (state_q == ACCESS) && !we_q;
  assign bus.ram_addr = addr_q;
  assign bus.ram_din  = din_q;
  assign bus.ram_size = size_q;
  assign bus.busy     = (state_q == ACCESS) || (state_q == DONE);

  assign bus.p0_ack   = (state_q == DONE) && !grant_q;
  assign bus.p1_ack   = (state_q == DONE) && grant_q;
  assign bus.p0_err   = (state_q == DONE) && !grant_q && err_q;
  assign bus.p1_err   = (state_q == DONE) && grant_q && err_q;
  assign bus.p0_rdata = rdata0_q;
  assign bus.p1_rdata = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed plus randomized bench for ram_arbiter; a pending-request model predicts each grant,
// the RAM bus contents, ack/err pulses and the per-port read-data registers.
module tb_ram_arbiter;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  ram_arbiter_if bus ();

  ram_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic        mPend [2];
  logic        mWe   [2];
  logic [31:0] mAddr [2];
  logic [31:0] mWdata[2];
  logic [1:0]  mSize [2];
  logic [31:0] mRdata[2];
  int          mLast;
  logic        bootLock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic getAck(input int p);
    return (p == 1) ? bus.p1_ack : bus.p0_ack;
  endfunction

  function automatic logic getErr(input int p);
    return (p == 1) ? bus.p1_err : bus.p0_err;
  endfunction

  function automatic logic [31:0] getRdata(input int p);
    return (p == 1) ? bus.p1_rdata : bus.p0_rdata;
  endfunction

  task automatic drivePort(input int p, input logic req);
    if (p == 0) begin
      bus.p0_req = req; bus.p0_we = mWe[0]; bus.p0_addr = mAddr[0];
      bus.p0_wdata = mWdata[0]; bus.p0_size = mSize[0];
    end else begin
      bus.p1_req = req; bus.p1_we = mWe[1]; bus.p1_addr = mAddr[1];
      bus.p1_wdata = mWdata[1]; bus.p1_size = mSize[1];
    end
  endtask

  task automatic applyStimulus(input int p, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [1:0] size);
    mPend[p] = 1'b1; mWe[p] = we; mAddr[p] = addr; mWdata[p] = wdata; mSize[p] = size;
    drivePort(p, 1'b1);
  endtask

  task automatic releasePort(input int p);
    mPend[p] = 1'b0;
    drivePort(p, 1'b0);
  endtask

  // Lock favours the loader; otherwise a lone requester wins, and contention alternates.
  function automatic int pickWinner();
    if (bootLock && mPend[0]) return 0;
    if (mPend[0] && mPend[1]) return (mLast == 0) ? 1 : 0;
    return mPend[0] ? 0 : 1;
  endfunction

  task automatic runAccess(input int readyDelay, input logic [31:0] dout, input bit timeoutCase);
    int p, q, cyc, cs, expCs;
    bit done;
    p = pickWinner(); q = 1 - p; mLast = p;
    cyc = 0; cs = 0; done = 1'b0;
    expCs = timeoutCase ? TIMEOUT : readyDelay;
    bus.ram_ready = 1'b0;
    bus.ram_dout  = $urandom;
    while (!done && cyc < TIMEOUT + 20) begin
      @(negedge clk);
      cyc++;
      if (bus.ram_cs) begin
        cs++;
        if (cs == 1) begin
          checkOutput($sformatf("p%0d latency", p), 32'(cyc), 32'd1);
          checkOutput($sformatf("p%0d ram_addr", p), bus.ram_addr, mAddr[p]);
          checkOutput($sformatf("p%0d ram_din", p), bus.ram_din, mWdata[p]);
          checkOutput($sformatf("p%0d ram_size", p), 32'(bus.ram_size), 32'(mSize[p]));
          checkOutput($sformatf("p%0d ram_we", p), 32'(bus.ram_we), 32'(mWe[p]));
          checkOutput($sformatf("p%0d ram_oe", p), 32'(bus.ram_oe), 32'(!mWe[p]));
          checkOutput($sformatf("p%0d busy access", p), 32'(bus.busy), 32'd1);
        end
        if (!timeoutCase && cs == readyDelay) begin
          bus.ram_dout  = dout;
          bus.ram_ready = 1'b1;
        end
      end else begin
        done = 1'b1;
        if (!timeoutCase && !mWe[p]) mRdata[p] = dout;
        checkOutput($sformatf("p%0d access cycles", p), 32'(cs), 32'(expCs));
        checkOutput($sformatf("p%0d ack", p), 32'(getAck(p)), 32'd1);
        checkOutput($sformatf("p%0d ack idle", q), 32'(getAck(q)), 32'd0);
        checkOutput($sformatf("p%0d err", p), 32'(getErr(p)), 32'(timeoutCase));
        checkOutput($sformatf("p%0d err idle", q), 32'(getErr(q)), 32'd0);
        checkOutput($sformatf("p%0d busy done", p), 32'(bus.busy), 32'd1);
        checkOutput($sformatf("p%0d strobes done", p), {30'd0, bus.ram_we, bus.ram_oe}, 32'd0);
        checkOutput($sformatf("p%0d rdata", p), getRdata(p), mRdata[p]);
        checkOutput($sformatf("p%0d rdata other", q), getRdata(q), mRdata[q]);
        releasePort(p);
        // Stray ready with junk data during DONE must be ignored.
        bus.ram_ready = 1'b1;
        bus.ram_dout  = $urandom;
      end
    end
    if (!done) checkOutput($sformatf("p%0d ack seen", p), 32'd0, 32'd1);
    @(negedge clk);
    bus.ram_ready = 1'b0;
    checkOutput($sformatf("p%0d ack one cycle", p), {30'd0, bus.p1_ack, bus.p0_ack}, 32'd0);
    checkOutput($sformatf("p%0d busy idle", p), 32'(bus.busy), 32'd0);
    checkOutput($sformatf("p%0d rdata held", p), getRdata(p), mRdata[p]);
  endtask

  initial begin
    int waitCnt;
    bus.boot_lock = 1'b0; bus.ram_ready = 1'b0; bus.ram_dout = '0;
    bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0; bus.p0_size = '0;
    bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0; bus.p1_size = '0;
    bootLock = 1'b0; mLast = 1;
    for (int i = 0; i < 2; i++) begin
      mPend[i] = 1'b0; mWe[i] = 1'b0; mAddr[i] = '0; mWdata[i] = '0; mSize[i] = '0; mRdata[i] = '0;
    end

    // Reset with both ports requesting.
    #1 rst_n = 1'b0;
    applyStimulus(0, 1'b1, 32'h0000_0100, 32'hCAFE_0001, 2'b11);
    applyStimulus(1, 1'b0, 32'h0000_0010, 32'h0, 2'b11);
    repeat (3) @(negedge clk);
    checkOutput("reset ram bus", {bus.ram_cs, bus.ram_we, bus.ram_oe, bus.busy, 28'd0}, 32'd0);
    checkOutput("reset ram_addr", bus.ram_addr, 32'd0);
    checkOutput("reset ram_din", bus.ram_din, 32'd0);
    checkOutput("reset ram_size", 32'(bus.ram_size), 32'd0);
    checkOutput("reset acks", {28'd0, bus.p0_ack, bus.p0_err, bus.p1_ack, bus.p1_err}, 32'd0);
    checkOutput("reset p0_rdata", bus.p0_rdata, 32'd0);
    checkOutput("reset p1_rdata", bus.p1_rdata, 32'd0);
    rst_n = 1'b1;

    // Port 0 wins the first contention, then port 1 reads with ready on the third ACCESS cycle.
    runAccess(2, 32'h1234_5678, 1'b0);
    runAccess(3, 32'hE3A0_0001, 1'b0);
    checkOutput("p1 boot word", bus.p1_rdata, 32'hE3A0_0001);

    // Both ports writing continuously: grants alternate.
    for (int i = 0; i < 4; i++) begin
      for (int p = 0; p < 2; p++)
        if (!mPend[p]) applyStimulus(p, 1'b1, $urandom, $urandom, 2'b11);
      runAccess(1, 32'hDEAD_BEEF, 1'b0);
    end

    // Loader lock starves port 1 until released.
    bootLock = 1'b1; bus.boot_lock = 1'b1;
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < 2; p++)
        if (!mPend[p]) applyStimulus(p, 1'b1, $urandom, $urandom, 2'b10);
      runAccess(1, 32'h0, 1'b0);
    end
    bootLock = 1'b0; bus.boot_lock = 1'b0;
    if (!mPend[0]) applyStimulus(0, 1'b1, $urandom, $urandom, 2'b11);
    runAccess(2, 32'h0, 1'b0);
    runAccess(1, 32'h0, 1'b0);

    // RAM never answers: watchdog completes with err, rdata untouched, next access is normal.
    applyStimulus(1, 1'b0, 32'h0000_2000, 32'h0, 2'b11);
    runAccess(0, 32'h0, 1'b1);
    applyStimulus(1, 1'b0, 32'h0000_2004, 32'h0, 2'b01);
    runAccess(4, 32'h5A5A_A5A5, 1'b0);

    // Reset pulsed in the middle of an ACCESS.
    applyStimulus(0, 1'b0, 32'h0000_0040, 32'h0, 2'b11);
    waitCnt = 0;
    while (!bus.ram_cs && waitCnt < 5) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("midreset cs before", 32'(bus.ram_cs), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset cs drop", {bus.ram_cs, bus.ram_we, bus.ram_oe, bus.busy, 28'd0}, 32'd0);
    checkOutput("midreset acks", {30'd0, bus.p0_ack, bus.p1_ack}, 32'd0);
    checkOutput("midreset rdata", bus.p1_rdata, 32'd0);
    mRdata[0] = '0; mRdata[1] = '0; mLast = 1;
    @(negedge clk);
    rst_n = 1'b1;
    runAccess(2, 32'h0BAD_F00D, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      for (int p = 0; p < 2; p++)
        if (!mPend[p] && $urandom_range(0, 1) == 1)
          applyStimulus(p, 1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)));
      if (!mPend[0] && !mPend[1])
        applyStimulus(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                      2'($urandom_range(0, 3)));
      bootLock = ($urandom_range(0, 3) == 0);
      bus.boot_lock = bootLock;
      runAccess(int'($urandom_range(1, 4)), $urandom, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter sharing the single basic_ram port between the boot file loader (port 0) and the ARMv4 core (port 1).
- Replaces the testbench-level ld_file mux with a sequenced, handshaked controller.
- Registers each access, holds RAM strobes until mem_done, and returns read data with a one-cycle ack.
- Grant policy is round-robin, with a loader-priority override and a ready-timeout watchdog.

Parameters:
- TIMEOUT, 64: max cycles in ACCESS waiting for ram_ready before the access is aborted (minimum 2).
- CNT_W, 7: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- boot_lock  input  1  1 = port 0 wins every arbitration (loader mode)
- p0_req  input  1  port 0 access request; held with fields stable until p0_ack
- p0_we  input  1  port 0 write (1) / read (0)
- p0_addr  input  32  port 0 byte address
- p0_wdata  input  32  port 0 write data
- p0_size  input  2  port 0 data size, RAM encoding (2'b11 = word)
- p0_ack  output  1  one-cycle completion pulse
- p0_err  output  1  one-cycle pulse coincident with p0_ack on timeout
- p0_rdata  output  32  read data, valid from p0_ack onward, held until the next port-0 read completes
- p1_req, p1_we, p1_addr, p1_wdata, p1_size, p1_ack, p1_err, p1_rdata: same as port 0, for the core
- ram_cs  output  1  RAM chip select
- ram_we  output  1  RAM write enable
- ram_oe  output  1  RAM output enable (= !ram_we while ram_cs is high)
- ram_addr  output  32  registered address to RAM
- ram_din  output  32  registered write data to RAM
- ram_size  output  2  registered data size to RAM
- ram_dout  input  32  RAM read data
- ram_ready  input  1  RAM mem_done
- busy  output  1  high in ACCESS or DONE

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - State is IDLE.
  - All outputs are 0, including rdata registers and RAM bus registers.
  - last_grant = 1, so port 0 wins the first contention.
  - Reset asserted mid-access drops ram_cs immediately; no ack is issued.
- IDLE:
  - ram_cs = 0.
  - If any req is high, select a winner as below.
  - Latch the winner's we/addr/wdata/size into the ram_* registers, set grant, clear the timeout counter, go to ACCESS.
  - RAM strobes are first high the cycle after req is sampled.
- Arbitration:
  - boot_lock = 1: port 0 wins if p0_req is high, otherwise port 1.
  - boot_lock = 0, single requester: that requester wins.
  - boot_lock = 0, both requesting: the port that is not last_grant wins.
  - last_grant updates on each grant.
- ACCESS:
  - ram_cs = 1; ram_we/ram_oe from the latched we; the bus is held stable.
  - ram_ready = 1 sampled: capture ram_dout into the granted port's rdata (reads only), go to DONE.
  - Timeout counter reaching TIMEOUT-1 without ready: go to DONE with the error flag set; rdata is unchanged.
- DONE (exactly one cycle):
  - ram_cs = 0, ram_we = 0, ram_oe = 0.
  - Granted port's ack = 1; err = 1 if timed out.
  - Next state is IDLE.
- Throughput:
  - Minimum 3 cycles per access: IDLE sample, 1 ACCESS, DONE.
  - ram_ready asserted in IDLE or DONE is ignored.
- Requester rules:
  - Change or drop req in the cycle after ack.
  - A req dropped mid-access does not abort the access; the ack is still pulsed.
  - A req asserted during another port's access waits.
  - boot_lock changes take effect at the next IDLE arbitration only.
- Writes: p*_rdata is not modified.

Test Plan:
- Reset with rst_n = 0, all reqs high: all outputs 0; on rst_n rise, p0 is granted first (last_grant = 1); ram_cs high one cycle after the first sampled IDLE.
- p1 read 0x00000010, RAM returns 0xE3A00001 with ready after 3 ACCESS cycles: p1_ack pulses exactly one cycle; p1_rdata = 0xE3A00001 and held; p0_ack stays 0.
- boot_lock = 0, both ports continuously requesting writes: grants alternate p0, p1, p0, p1; each ack matches ram_addr/ram_din of its own port.
- boot_lock = 1, both requesting continuously: p0 granted every access and p1 never acked; drop boot_lock → p1 granted at the next IDLE.
- ram_ready never asserted, TIMEOUT = 64: ack and err pulse together 64 cycles after ram_cs rises; rdata unchanged; arbiter returns to IDLE and serves the next request normally.
- rst_n pulsed low mid-ACCESS: ram_cs drops asynchronously; no ack; a post-reset request completes normally.
